// File: rtl/run_control_if.sv
// Run/pause controller bus: front-panel buttons, sequencer handshake and status.
interface run_control_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               exec_btn;
  logic               step_btn;
  logic               is_halt_commanded;
  logic               phase_last;
  logic               run_enable;
  logic               running;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output exec_btn, step_btn, is_halt_commanded, phase_last,
    input  run_enable, running, halted, instr_count
  );

  modport slave (
    input  exec_btn, step_btn, is_halt_commanded, phase_last,
    output run_enable, running, halted, instr_count
  );
endinterface

// File: rtl/run_control.sv
// Run/step/halt controller: debounced front-panel buttons gate the phase counter
// and count completed instructions.
module run_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic         clock,
  input  logic         reset,
  run_control_if.slave bus
);

  localparam int unsigned NBTN = 2;
  localparam int unsigned DB_W = 8;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  // Bit 0 is exec, bit 1 is step.
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] level_q;
  logic [NBTN-1:0] level_prev_q;
  logic [NBTN-1:0] pulse;
  logic [DB_W-1:0] db_cnt_q [NBTN];

  logic exec_pulse;
  logic step_pulse;

  state_t state_q, state_d;
  logic   halt_cause_q, halt_cause_d;
  logic   run_enable_q, run_enable_d;
  logic   running_q, running_d;
  logic   halted_q, halted_d;
  logic [COUNT_W-1:0] count_q;

  assign btn_raw    = {bus.step_btn, bus.exec_btn};
  assign pulse      = level_q & ~level_prev_q;
  assign exec_pulse = pulse[0];
  assign step_pulse = pulse[1];

  // Two-flop synchronizers for the asynchronous buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Previous debounced level for rising-edge pulse generation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_prev_q <= '0;
    else        level_prev_q <= level_q;
  end

  // State, latched stop cause and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_STOPPED;
      halt_cause_q <= 1'b0;
      run_enable_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
      run_enable_q <= run_enable_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state logic; a stop request mid-instruction drains to the instruction boundary.
  always_comb begin
    state_d      = state_q;
    halt_cause_d = halt_cause_q;
    unique case (state_q)
      ST_STOPPED: begin
        halt_cause_d = 1'b0;
        if (exec_pulse)      state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (bus.is_halt_commanded || exec_pulse) begin
          halt_cause_d = bus.is_halt_commanded;
          if (bus.phase_last) state_d = bus.is_halt_commanded ? ST_HALTED : ST_STOPPED;
          else                state_d = ST_DRAIN;
        end
      end
      ST_STEP, ST_DRAIN: begin
        halt_cause_d = halt_cause_q | bus.is_halt_commanded;
        if (bus.phase_last) state_d = halt_cause_d ? ST_HALTED : ST_STOPPED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_STOPPED;
    endcase
    run_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    running_d    = (state_d == ST_RUN);
    halted_d     = (state_d == ST_HALTED);
  end

  // Completed-instruction counter, wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           count_q <= '0;
    else if (run_enable_q && bus.phase_last) count_q <= count_q + COUNT_W'(1);
  end

  assign bus.run_enable  = run_enable_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: directed scenarios plus randomized run against a behavioural model.
module tb_run_control;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  run_control_if #(.COUNT_W(CW)) bus ();

  run_control #(.DEBOUNCE_CYCLES(DB), .COUNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // Behavioural model: modes 0 stopped, 1 run, 2 step, 3 drain, 4 halted.
  int m_mode;
  bit m_halt;
  int m_count;
  bit lvl_e, lvl_s, pend_e, pend_s;
  bit hist_e[$];
  bit hist_s[$];

  // True when the samples that have crossed the synchronizer window all equal v.
  function automatic bit settled(input bit q[$], input bit v);
    for (int i = 2; i < DB + 2; i++) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_halt = 0; m_count = 0;
    lvl_e = 0; lvl_s = 0; pend_e = 0; pend_s = 0;
    hist_e = {}; hist_s = {};
    for (int i = 0; i < DB + 2; i++) begin
      hist_e.push_back(1'b0);
      hist_s.push_back(1'b0);
    end
  endtask

  task automatic model_clock();
    bit hlt, pl;
    hlt = bus.is_halt_commanded;
    pl  = bus.phase_last;
    if (m_mode inside {1, 2, 3} && pl) m_count = (m_count + 1) % (1 << CW);
    case (m_mode)
      0: begin
        m_halt = 0;
        if (pend_e)      m_mode = 1;
        else if (pend_s) m_mode = 2;
      end
      1: if (hlt || pend_e) begin
        m_halt = hlt;
        m_mode = pl ? (hlt ? 4 : 0) : 3;
      end
      2, 3: begin
        m_halt = m_halt | hlt;
        if (pl) m_mode = m_halt ? 4 : 0;
      end
      default: ;
    endcase
    hist_e.push_front(bus.exec_btn); void'(hist_e.pop_back());
    hist_s.push_front(bus.step_btn); void'(hist_s.pop_back());
    pend_e = 0;
    pend_s = 0;
    if (settled(hist_e, !lvl_e)) begin lvl_e = !lvl_e; pend_e = lvl_e; end
    if (settled(hist_s, !lvl_s)) begin lvl_s = !lvl_s; pend_s = lvl_s; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else        model_clock();
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.exec_btn = 0; bus.step_btn = 0; bus.is_halt_commanded = 0; bus.phase_last = 0;
    idle(3);
    checks++; if (bus.run_enable !== 1'b0) $display("FAIL reset_run_enable: got %b want 0", bus.run_enable); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL reset_running: got %b want 0", bus.running); else passed++;
    checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted); else passed++;
    checks++; if (bus.instr_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.instr_count); else passed++;
    reset = 1'b1;
    idle(3);
    checks++; if (bus.run_enable !== 1'b0) $display("FAIL idle_run_enable: got %b want 0", bus.run_enable); else passed++;
  endtask

  task automatic test_exec_press();
    int n;
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.run_enable !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n != 7) $display("FAIL exec_latency: got %0d cycles want 7", n); else passed++;
    checks++; if (bus.running !== 1'b1) $display("FAIL exec_running: got %b want 1", bus.running); else passed++;
    idle(3);
    bus.exec_btn = 0;
    idle(10);
    checks++; if (bus.running !== 1'b1) $display("FAIL exec_single_pulse: running got %b want 1", bus.running); else passed++;
  endtask

  task automatic test_bounce_pause();
    int n;
    logic [CW-1:0] c0;
    for (int i = 0; i < 6; i++) begin
      bus.exec_btn = (i % 2 == 0);
      @(negedge clock);
    end
    idle(8);
    checks++; if (bus.running !== 1'b1) $display("FAIL bounce_ignored: running got %b want 1", bus.running); else passed++;
    c0 = bus.instr_count;
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b0) begin
      @(negedge clock);
      n++;
    end
    checks++; if (bus.run_enable !== 1'b1 || n >= 20) $display("FAIL drain_entry: run_enable got %b after %0d cycles want 1", bus.run_enable, n); else passed++;
    idle(4);
    checks++; if (bus.run_enable !== 1'b1) $display("FAIL drain_hold: run_enable got %b want 1", bus.run_enable); else passed++;
    bus.phase_last = 1;
    @(negedge clock);
    bus.phase_last = 0;
    checks++; if (bus.run_enable !== 1'b0) $display("FAIL pause_done: run_enable got %b want 0", bus.run_enable); else passed++;
    checks++; if (bus.instr_count !== CW'(c0 + 1)) $display("FAIL pause_count: got %0d want %0d", bus.instr_count, CW'(c0 + 1)); else passed++;
    bus.exec_btn = 0;
    idle(10);
    checks++; if (bus.running !== 1'b0 || bus.halted !== 1'b0) $display("FAIL pause_stopped: running %b halted %b want 0 0", bus.running, bus.halted); else passed++;
  endtask

  task automatic test_step();
    int n;
    logic [CW-1:0] c0;
    c0 = bus.instr_count;
    bus.step_btn = 1;
    n = 0;
    while (n < 20 && bus.run_enable !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n != 7) $display("FAIL step_latency: got %0d cycles want 7", n); else passed++;
    @(negedge clock);
    checks++; if (bus.run_enable !== 1'b1) $display("FAIL step_cycle2: run_enable got %b want 1", bus.run_enable); else passed++;
    bus.phase_last = 1;
    @(negedge clock);
    bus.phase_last = 0;
    checks++; if (bus.run_enable !== 1'b0) $display("FAIL step_drop: run_enable got %b want 0", bus.run_enable); else passed++;
    checks++; if (bus.instr_count !== CW'(c0 + 1)) $display("FAIL step_count: got %0d want %0d", bus.instr_count, CW'(c0 + 1)); else passed++;
    idle(8);
    bus.step_btn = 0;
    idle(10);
    checks++; if (bus.run_enable !== 1'b0 || bus.halted !== 1'b0) $display("FAIL step_stopped: run_enable %b halted %b want 0 0", bus.run_enable, bus.halted); else passed++;
  endtask

  task automatic test_halt();
    int n;
    logic [CW-1:0] c0;
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    bus.exec_btn = 0;
    bus.is_halt_commanded = 1;
    @(negedge clock);
    bus.is_halt_commanded = 0;
    bus.phase_last = 1;
    @(negedge clock);
    bus.phase_last = 0;
    checks++; if (bus.halted !== 1'b1) $display("FAIL halt_entry: halted got %b want 1", bus.halted); else passed++;
    checks++; if (bus.run_enable !== 1'b0) $display("FAIL halt_run_enable: got %b want 0", bus.run_enable); else passed++;
    c0 = bus.instr_count;
    bus.exec_btn = 1; idle(10); bus.exec_btn = 0; idle(8);
    bus.step_btn = 1; bus.phase_last = 1; idle(10); bus.step_btn = 0; bus.phase_last = 0; idle(8);
    checks++; if (bus.halted !== 1'b1 || bus.run_enable !== 1'b0) $display("FAIL halt_sticky: halted %b run_enable %b want 1 0", bus.halted, bus.run_enable); else passed++;
    checks++; if (bus.instr_count !== c0) $display("FAIL halt_count_frozen: got %0d want %0d", bus.instr_count, c0); else passed++;
  endtask

  task automatic test_wrap();
    int n;
    reset = 0; idle(2); reset = 1; idle(1);
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    bus.exec_btn = 0;
    bus.phase_last = 1;
    idle(15);
    checks++; if (bus.instr_count !== 4'd15) $display("FAIL wrap_pre: got %0d want 15", bus.instr_count); else passed++;
    @(negedge clock);
    bus.phase_last = 0;
    checks++; if (bus.instr_count !== 4'd0) $display("FAIL wrap_zero: got %0d want 0", bus.instr_count); else passed++;
    idle(8);
  endtask

  task automatic test_reset_drain();
    int n;
    reset = 0; idle(2); reset = 1; idle(1);
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    bus.exec_btn = 0;
    bus.phase_last = 1;
    idle(5);
    bus.phase_last = 0;
    idle(8);
    bus.exec_btn = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b0) begin
      @(negedge clock);
      n++;
    end
    checks++; if (bus.run_enable !== 1'b1 || bus.instr_count !== 4'd5) $display("FAIL drain_setup: run_enable %b count %0d want 1 5", bus.run_enable, bus.instr_count); else passed++;
    #2 reset = 0;
    #1;
    checks++; if (bus.run_enable !== 1'b0 || bus.running !== 1'b0 || bus.halted !== 1'b0 || bus.instr_count !== 4'd0)
      $display("FAIL async_reset: run_enable %b running %b halted %b count %0d want 0 0 0 0", bus.run_enable, bus.running, bus.halted, bus.instr_count);
    else passed++;
    @(negedge clock);
    reset = 1;
    n = 0;
    while (n < 20 && bus.running !== 1'b1) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n != 7) $display("FAIL held_at_reset: running after %0d cycles want 7", n); else passed++;
    bus.exec_btn = 0;
    idle(8);
  endtask

  task automatic test_random();
    int e_hold, s_hold;
    reset = 0; idle(2); reset = 1;
    e_hold = 0; s_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clock);
      checks++; if (bus.run_enable !== (m_mode inside {1, 2, 3})) $display("FAIL rnd_run_enable cyc %0d: got %b mode %0d", cyc, bus.run_enable, m_mode); else passed++;
      checks++; if (bus.running !== (m_mode == 1)) $display("FAIL rnd_running cyc %0d: got %b mode %0d", cyc, bus.running, m_mode); else passed++;
      checks++; if (bus.halted !== (m_mode == 4)) $display("FAIL rnd_halted cyc %0d: got %b mode %0d", cyc, bus.halted, m_mode); else passed++;
      checks++; if (bus.instr_count !== CW'(m_count)) $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, bus.instr_count, m_count); else passed++;
      if (e_hold == 0) begin bus.exec_btn = ~bus.exec_btn; e_hold = $urandom_range(1, 10); end
      else e_hold--;
      if (s_hold == 0) begin bus.step_btn = ~bus.step_btn; s_hold = $urandom_range(1, 10); end
      else s_hold--;
      bus.is_halt_commanded = ($urandom_range(0, 79) == 0);
      bus.phase_last = ($urandom_range(0, 2) == 0);
      if (reset == 1'b0) reset = 1;
      else if ($urandom_range(0, 299) == 0) #2 reset = 0;
    end
    bus.exec_btn = 0; bus.step_btn = 0; bus.is_halt_commanded = 0; bus.phase_last = 0;
  endtask

  initial begin
    test_reset();
    test_exec_press();
    test_bounce_pause();
    test_step();
    test_halt();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
